// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb - parametrised register file with write-to-read bypass,
// per-register pending scoreboard and a sequential clear engine.
//
// Sits between decode (reads, reservations) and writeback (writes).
//
// Parameters:
//   DATA_W  width of each register
//   ADDR_W  address width; DEPTH = 2**ADDR_W entries
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   we/waddr/wdata     writeback port (also retires a pending reservation)
//   raddr1/rdata1      read port 1, combinational, with bypass from writeback
//   raddr2/rdata2      read port 2, combinational, with bypass from writeback
//   rsv_en/rsv_addr    mark a register as having an outstanding result
//   pend1/pend2        pending status of raddr1/raddr2
//   clr_req/clr_busy   start a DEPTH-cycle clear sweep / sweep in progress
//
// Build option:
//   REGFILE_ZERO_REG_EN  when defined, entry 0 reads as zero, is never
//                        written and can never be pending.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend1,
  output logic              pend2,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic idle;
  logic upd_en;   // normal write/reserve traffic is accepted this edge
  logic wr_ok;    // write targets a writable entry
  logic rsv_ok;   // reservation targets a reservable entry
  logic byp1, byp2;

  assign idle = (state == IDLE);
  // A clear request on the IDLE edge takes priority over same-cycle traffic.
  assign upd_en = idle && !clr_req;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok  = we && (waddr != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);
`else
  assign wr_ok  = we;
  assign rsv_ok = rsv_en;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    unique case (state)
      IDLE:  if (clr_req)         state_nxt = CLEAR;
      CLEAR: if (idx == LAST_IDX) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clr_busy = (state == CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Sweep index: restarts at 0 on entry, wraps back to 0 after the last entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    if (!rst_n)                 idx <= '0;
    else if (idle && clr_req)   idx <= '0;
    else if (state == CLEAR)    idx <= idx + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is deliberately built from resettable flops rather than
    // a RAM macro: reset must zero every entry immediately, even mid-sweep.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (upd_en && wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard. The set is applied after the clear so that a new
  // reservation to the register being written back supersedes the retirement.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (state == CLEAR) begin
      pending[idx] <= 1'b0;
    end else if (upd_en) begin
      if (wr_ok)  pending[waddr]    <= 1'b0;
      if (rsv_ok) pending[rsv_addr] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Bypass is only live in IDLE; during a sweep reads see the
  // partially cleared array.
  // ---------------------------------------------------------------------------
  assign byp1 = idle && wr_ok && (waddr == raddr1);
  assign byp2 = idle && wr_ok && (waddr == raddr2);

  always_comb begin
    rdata1 = byp1 ? wdata : mem[raddr1];
    pend1  = pending[raddr1] && !byp1;
`ifdef REGFILE_ZERO_REG_EN
    if (raddr1 == '0) begin
      rdata1 = '0;
      pend1  = 1'b0;
    end
`endif
  end

  always_comb begin
    rdata2 = byp2 ? wdata : mem[raddr2];
    pend2  = pending[raddr2] && !byp2;
`ifdef REGFILE_ZERO_REG_EN
    if (raddr2 == '0) begin
      rdata2 = '0;
      pend2  = 1'b0;
    end
`endif
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle 16x19 register file in the CPU datapath.
- Adds a configurable width and depth, plus write-to-read bypass.
- Adds a per-register pending scoreboard for multi-cycle ops, and a sequential clear engine that zeroes the array one entry per cycle.
- Sits between decode (read/reserve) and writeback (write) stages.

Parameters:
DATA_W, 19, width of each register in bits
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W entries

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr1  in  ADDR_W  read port 1 address
raddr2  in  ADDR_W  read port 2 address
rdata1  out  DATA_W  read port 1 data (combinational)
rdata2  out  DATA_W  read port 2 data (combinational)
rsv_en  in  1  mark register rsv_addr pending (result outstanding)
rsv_addr  in  ADDR_W  register to reserve
pend1  out  1  raddr1 has an outstanding result
pend2  out  1  raddr2 has an outstanding result
clr_req  in  1  start a full-array clear sweep
clr_busy  out  1  clear sweep in progress

Behaviour:
- Clocking and reset
  - One clock: clk. Reset rst_n is asynchronous, active-low.
  - On reset assertion:
    - all DEPTH entries = 0
    - all pending bits = 0
    - FSM = IDLE, sweep index = 0, clr_busy = 0
  - Therefore rdata1/2 = 0 and pend1/2 = 0 immediately on reset.
- Reads: combinational, zero latency. rdataN = array[raddrN], except for bypass.
- Bypass: in IDLE, if we=1 and waddr==raddrN, then rdataN = wdata in the same cycle.
- Write: in IDLE, array[waddr] <= wdata at posedge when we=1.
- Scoreboard update at posedge, in IDLE:
  - rsv_en=1 sets pending[rsv_addr].
  - we=1 clears pending[waddr].
  - Same address, both events in the same cycle: set wins (a new reservation supersedes the completed one). The data write still occurs.
- pendN = pending[raddrN] AND NOT (we AND waddr==raddrN AND IDLE). A bypass hit reports not-pending.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on posedge with clr_req=1. Index <= 0.
    - In that same edge, any we/rsv_en is ignored. The clear takes priority.
  - CLEAR, each cycle:
    - array[index] <= 0, pending[index] <= 0, index <= index+1
  - When index == DEPTH-1: the final entry is cleared and the FSM returns to IDLE. Index wraps to 0.
  - Sweep length is exactly DEPTH cycles, with clr_busy=1 in each of them.
  - Concurrent inputs in CLEAR:
    - we, rsv_en and clr_req are ignored (no retrigger, no queuing).
    - Bypass is disabled; reads return current array contents, which are partially cleared.
  - clr_busy is driven from the state register: high exactly while in CLEAR.
- Reset mid-sweep: aborts immediately to IDLE, with the whole array 0.
- Address width: all addresses are full-range; no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- When defined, entry 0 is hard-wired to zero:
  - writes to address 0 are discarded;
  - rsv_en to address 0 has no effect;
  - rdataN = 0 and pendN = 0 whenever raddrN==0, including when a bypass would otherwise hit.
- When undefined, entry 0 is an ordinary register.

Test Plan:
1. Reset then read: rst_n low, release; raddr1=3, raddr2=15 -> rdata1=rdata2=0, pend1=pend2=0, clr_busy=0.
2. Write and bypass: we=1, waddr=5, wdata=19'h7_ABCD, raddr1=5 -> rdata1=19'h7_ABCD in the same cycle. Next cycle with we=0 -> rdata1 still 19'h7_ABCD.
3. Scoreboard:
   - rsv_en=1, rsv_addr=7, then raddr1=7 -> pend1=1.
   - Later we=1, waddr=7, wdata=19'h00042 -> pend1=0 and rdata1=19'h00042 in the same cycle.
   - Simultaneous rsv_en=1 and we=1 both at address 7 -> pend1=1 on the next cycle, data = new wdata.
4. Clear sweep:
   - Preload all 16 entries with nonzero values, then pulse clr_req -> clr_busy=1 for exactly 16 cycles.
   - we pulses during the sweep are ignored; afterwards all entries read 0 and all pend=0.
5. Reset mid-sweep: assert rst_n low at sweep index 6 -> clr_busy=0 immediately; all entries read 0. A fresh write afterwards is accepted on the next edge.
6. With REGFILE_ZERO_REG_EN defined: we=1, waddr=0, wdata=19'h1FFFF, raddr1=0 -> rdata1=0 in that cycle and after. rsv_en at address 0 -> pend1=0.
